seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 274 +++++++++++++++++++++++++++
 tb/tb_seq_alu.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: sequential integer ALU.
// Base operations complete at the accept edge. Multiply and divide iterate one
// bit per cycle on operand magnitudes, then fix up signs at completion.

module seq_alu #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      func,
  input  logic            sub_sra,
  input  logic            m_ext,
  input  logic            kill_i,
  output logic [XLEN-1:0] s,
  output logic            out_valid,
  output logic            eq,
  output logic            ls,
  output logic            lu
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0] count_q, count_d;
  logic [XLEN-1:0]  accHi_q, accHi_d;
  logic [XLEN-1:0]  accLo_q, accLo_d;
  logic [XLEN-1:0]  opB_q, opB_d;
  logic [1:0]       func_q, func_d;
  logic             negRes_q, negRes_d;
  logic             negRem_q, negRem_d;
  logic             zeroDiv_q, zeroDiv_d;
  logic             eqPend_q, eqPend_d;
  logic             lsPend_q, lsPend_d;
  logic             luPend_q, luPend_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic             eq_q, eq_d;
  logic             ls_q, ls_d;
  logic             lu_q, lu_d;

  logic             accept;
  logic             lastStep;
  logic [SHW-1:0]   shamt;
  logic [XLEN-1:0]  sraRes;
  logic [XLEN-1:0]  baseRes;
  logic             cmpEq, cmpLs, cmpLu;
  logic             aSgn, bSgn, aNeg, bNeg;
  logic [XLEN-1:0]  aMag, bMag;

  logic [XLEN:0]     mulSum;
  logic [2*XLEN-1:0] mulProd;
  logic [2*XLEN-1:0] mulFinal;
  logic [XLEN-1:0]   mulRes;

  logic [XLEN:0]    divShift;
  logic             qBit;
  logic [XLEN-1:0]  divDiff, divRem, divQuot;
  logic [XLEN-1:0]  quotRes, remRes, divRes;

  assign ready_o   = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign s         = result_q;
  assign eq        = eq_q;
  assign ls        = ls_q;
  assign lu        = lu_q;

  // A kill in IDLE suppresses the accept on that edge.
  assign accept   = (state_q == IDLE) && valid_i && !kill_i;
  assign lastStep = (count_q == '0);

  assign shamt  = b[SHW-1:0];
  assign sraRes = $signed(a) >>> shamt;
  assign cmpEq  = (a == b);
  assign cmpLs  = ($signed(a) < $signed(b));
  assign cmpLu  = (a < b);

  // Single-cycle base operation result, selected by func.
  always_comb begin
    baseRes = '0;
    case (func)
      3'b000:  baseRes = sub_sra ? (a - b) : (a + b);
      3'b001:  baseRes = a << shamt;
      3'b010:  baseRes = {{(XLEN-1){1'b0}}, cmpLs};
      3'b011:  baseRes = {{(XLEN-1){1'b0}}, cmpLu};
      3'b100:  baseRes = a ^ b;
      3'b101:  baseRes = sub_sra ? sraRes : (a >> shamt);
      3'b110:  baseRes = a | b;
      3'b111:  baseRes = a & b;
      default: baseRes = '0;
    endcase
  end

  // Operand signedness for M ops: mulh s*s, mulhsu s*u, div/rem signed when func[0]=0.
  always_comb begin
    aSgn = 1'b0;
    bSgn = 1'b0;
    if (func[2]) begin
      aSgn = ~func[0];
      bSgn = ~func[0];
    end else begin
      aSgn = (func[1:0] == 2'b01) || (func[1:0] == 2'b10);
      bSgn = (func[1:0] == 2'b01);
    end
  end

  assign aNeg = aSgn & a[XLEN-1];
  assign bNeg = bSgn & b[XLEN-1];
  assign aMag = aNeg ? -a : a;
  assign bMag = bNeg ? -b : b;

  // Shift-add step: {accHi,accLo} holds partial product over remaining multiplier bits.
  always_comb begin
    mulSum   = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, opB_q} : '0);
    mulProd  = {mulSum, accLo_q[XLEN-1:1]};
    mulFinal = negRes_q ? -mulProd : mulProd;
    mulRes   = (func_q == 2'b00) ? mulFinal[XLEN-1:0] : mulFinal[2*XLEN-1:XLEN];
  end

  // Restoring division step: accHi is the partial remainder, accLo shifts dividend out and quotient in.
  always_comb begin
    divShift = {accHi_q, accLo_q[XLEN-1]};
    qBit     = (divShift >= {1'b0, opB_q});
    divDiff  = divShift[XLEN-1:0] - opB_q;
    divRem   = qBit ? divDiff : divShift[XLEN-1:0];
    divQuot  = {accLo_q[XLEN-2:0], qBit};
    quotRes  = zeroDiv_q ? '1 : (negRes_q ? -divQuot : divQuot);
    remRes   = negRem_q ? -divRem : divRem;
    divRes   = func_q[1] ? remRes : quotRes;
  end

  // Next-state logic; kill wins over step completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!m_ext)       state_d = DONE;
          else if (func[2]) state_d = DIV;
          else              state_d = MUL;
        end
      end
      MUL, DIV: begin
        if (kill_i)        state_d = IDLE;
        else if (lastStep) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: operand capture at accept, one iteration per busy cycle, result write at completion.
  always_comb begin
    count_d   = count_q;
    accHi_d   = accHi_q;
    accLo_d   = accLo_q;
    opB_d     = opB_q;
    func_d    = func_q;
    negRes_d  = negRes_q;
    negRem_d  = negRem_q;
    zeroDiv_d = zeroDiv_q;
    eqPend_d  = eqPend_q;
    lsPend_d  = lsPend_q;
    luPend_d  = luPend_q;
    result_d  = result_q;
    eq_d      = eq_q;
    ls_d      = ls_q;
    lu_d      = lu_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!m_ext) begin
            result_d = baseRes;
            eq_d     = cmpEq;
            ls_d     = cmpLs;
            lu_d     = cmpLu;
          end else begin
            count_d   = CNT_W'(XLEN - 1);
            func_d    = func[1:0];
            accHi_d   = '0;
            accLo_d   = func[2] ? aMag : bMag;
            opB_d     = func[2] ? bMag : aMag;
            negRes_d  = aNeg ^ bNeg;
            negRem_d  = aNeg;
            zeroDiv_d = func[2] & (b == '0);
            eqPend_d  = cmpEq;
            lsPend_d  = cmpLs;
            luPend_d  = cmpLu;
          end
        end
      end
      MUL: begin
        if (!kill_i) begin
          accHi_d = mulProd[2*XLEN-1:XLEN];
          accLo_d = mulProd[XLEN-1:0];
          if (lastStep) begin
            result_d = mulRes;
            eq_d     = eqPend_q;
            ls_d     = lsPend_q;
            lu_d     = luPend_q;
          end else begin
            count_d = count_q - CNT_W'(1);
          end
        end
      end
      DIV: begin
        if (!kill_i) begin
          accHi_d = divRem;
          accLo_d = divQuot;
          if (lastStep) begin
            result_d = divRes;
            eq_d     = eqPend_q;
            ls_d     = lsPend_q;
            lu_d     = luPend_q;
          end else begin
            count_d = count_q - CNT_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // State and datapath registers, cleared asynchronously while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      accHi_q   <= '0;
      accLo_q   <= '0;
      opB_q     <= '0;
      func_q    <= '0;
      negRes_q  <= 1'b0;
      negRem_q  <= 1'b0;
      zeroDiv_q <= 1'b0;
      eqPend_q  <= 1'b0;
      lsPend_q  <= 1'b0;
      luPend_q  <= 1'b0;
      result_q  <= '0;
      eq_q      <= 1'b0;
      ls_q      <= 1'b0;
      lu_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      accHi_q   <= accHi_d;
      accLo_q   <= accLo_d;
      opB_q     <= opB_d;
      func_q    <= func_d;
      negRes_q  <= negRes_d;
      negRem_q  <= negRem_d;
      zeroDiv_q <= zeroDiv_d;
      eqPend_q  <= eqPend_d;
      lsPend_q  <= lsPend_d;
      luPend_q  <= luPend_d;
      result_q  <= result_d;
      eq_q      <= eq_d;
      ls_q      <= ls_d;
      lu_q      <= lu_d;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed vectors against a behavioural model of seq_alu (XLEN=64).
// A compare process checks outputs every cycle against a queue of expected results.

module tb_seq_alu;

  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

  logic        clk;
  logic        rst_n;
  logic        valid_i;
  logic        ready_o;
  logic [63:0] a;
  logic [63:0] b;
  logic [2:0]  func;
  logic        sub_sra;
  logic        m_ext;
  logic        kill_i;
  logic [63:0] s;
  logic        out_valid;
  logic        eq;
  logic        ls;
  logic        lu;

  seq_alu #(.XLEN(64), .CNT_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .a(a), .b(b), .func(func), .sub_sra(sub_sra), .m_ext(m_ext),
    .kill_i(kill_i), .s(s), .out_valid(out_valid), .eq(eq), .ls(ls), .lu(lu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] s;
    logic        eq;
    logic        ls;
    logic        lu;
    int          acc;
    int          due;
  } exp_t;

  exp_t        expQ[$];
  int          checks   = 0;
  int          failures = 0;
  int          cycNow   = 0;
  logic [63:0] holdS    = '0;
  logic        holdEq   = 1'b0;
  logic        holdLs   = 1'b0;
  logic        holdLu   = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycNow);
    end
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %b, expected %b (cycle %0d)", name, actual, expected, cycNow);
    end
  endtask

  // Result as defined by the operation table, using plain wide arithmetic.
  function automatic logic [63:0] modelAlu(input logic [63:0] x, input logic [63:0] y,
                                           input logic [2:0] fn, input logic ss, input logic mx);
    logic [127:0] p;
    logic [5:0]   sh;
    logic [63:0]  r;
    logic         ovf;
    sh  = y[5:0];
    r   = '0;
    p   = '0;
    ovf = (x == MINV) && (y == ALL1);
    if (!mx) begin
      case (fn)
        3'd0: r = ss ? x - y : x + y;
        3'd1: r = x << sh;
        3'd2: r = ($signed(x) < $signed(y)) ? 64'd1 : 64'd0;
        3'd3: r = (x < y) ? 64'd1 : 64'd0;
        3'd4: r = x ^ y;
        3'd5: if (ss) r = $signed(x) >>> sh; else r = x >> sh;
        3'd6: r = x | y;
        default: r = x & y;
      endcase
    end else begin
      case (fn)
        3'd0: r = x * y;
        3'd1: begin p = $signed({{64{x[63]}}, x}) * $signed({{64{y[63]}}, y}); r = p[127:64]; end
        3'd2: begin p = $signed({{64{x[63]}}, x}) * $signed({64'd0, y}); r = p[127:64]; end
        3'd3: begin p = {64'd0, x} * {64'd0, y}; r = p[127:64]; end
        3'd4: if (y == 0) r = ALL1; else if (ovf) r = x; else r = $signed(x) / $signed(y);
        3'd5: if (y == 0) r = ALL1; else r = x / y;
        3'd6: if (y == 0) r = x; else if (ovf) r = 64'd0; else r = $signed(x) % $signed(y);
        default: if (y == 0) r = x; else r = x % y;
      endcase
    end
    return r;
  endfunction

  // Drive one request at a negedge; optionally queue the expected result.
  task automatic startOp(input logic [63:0] x, input logic [63:0] y, input logic [2:0] fn,
                         input logic ss, input logic mx, input logic doPush);
    int   n;
    exp_t e;
    n = 0;
    while (!ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkBit("start_ready", ready_o, 1'b1);
    a       = x;
    b       = y;
    func    = fn;
    sub_sra = ss;
    m_ext   = mx;
    valid_i = 1'b1;
    if (doPush) begin
      e.s   = modelAlu(x, y, fn, ss, mx);
      e.eq  = (x == y);
      e.ls  = ($signed(x) < $signed(y));
      e.lu  = (x < y);
      e.acc = cycNow + 1;
      e.due = e.acc + (mx ? 64 : 0);
      expQ.push_back(e);
    end
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (expQ.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkBit({name, "_drained"}, expQ.size() == 0, 1'b1);
    expQ.delete();
  endtask

  // Pin the model to a hand-computed value, then run the operation through the DUT.
  task automatic applyStimulus(input string name, input logic [63:0] x, input logic [63:0] y,
                               input logic [2:0] fn, input logic ss, input logic mx,
                               input logic [63:0] litS);
    checkOutput({name, "_model"}, modelAlu(x, y, fn, ss, mx), litS);
    startOp(x, y, fn, ss, mx, 1'b1);
    drain(name);
  endtask

  // Every cycle: a due result must appear exactly then; otherwise outputs hold and out_valid is low.
  initial begin
    forever begin
      @(posedge clk);
      cycNow++;
      #1;
      if (expQ.size() > 0 && cycNow >= expQ[0].acc)
        checkBit("ready_busy", ready_o, 1'b0);
      if (expQ.size() > 0 && cycNow == expQ[0].due) begin
        checkBit("out_valid", out_valid, 1'b1);
        checkOutput("s", s, expQ[0].s);
        checkBit("eq", eq, expQ[0].eq);
        checkBit("ls", ls, expQ[0].ls);
        checkBit("lu", lu, expQ[0].lu);
        holdS  = expQ[0].s;
        holdEq = expQ[0].eq;
        holdLs = expQ[0].ls;
        holdLu = expQ[0].lu;
        void'(expQ.pop_front());
      end else begin
        checkBit("quiet_valid", out_valid, 1'b0);
        checkOutput("hold_s", s, holdS);
        checkBit("hold_eq", eq, holdEq);
        checkBit("hold_ls", ls, holdLs);
        checkBit("hold_lu", lu, holdLu);
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence: reset, base ops, M ops and corner cases, kill, mid-op reset.
  initial begin
    rst_n   = 1'b1;
    valid_i = 1'b0;
    a       = '0;
    b       = '0;
    func    = '0;
    sub_sra = 1'b0;
    m_ext   = 1'b0;
    kill_i  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_s", s, 64'd0);
    checkBit("rst_valid", out_valid, 1'b0);
    checkBit("rst_eq", eq, 1'b0);
    checkBit("rst_ls", ls, 1'b0);
    checkBit("rst_lu", lu, 1'b0);
    checkBit("rst_ready", ready_o, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    $display("[TB] reset released, starting directed vectors");

    applyStimulus("sub",     64'd5,    64'd7,  3'b000, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE);
    applyStimulus("add",     64'd3,    64'd4,  3'b000, 1'b0, 1'b0, 64'd7);
    applyStimulus("add_eq",  64'd9,    64'd9,  3'b000, 1'b0, 1'b0, 64'd18);
    applyStimulus("sll",     64'd1,    64'd65, 3'b001, 1'b0, 1'b0, 64'd2);
    applyStimulus("sra",     MINV,     64'd4,  3'b101, 1'b1, 1'b0, 64'hF800_0000_0000_0000);
    applyStimulus("srl",     MINV,     64'd4,  3'b101, 1'b0, 1'b0, 64'h0800_0000_0000_0000);
    applyStimulus("slt",     ALL1,     64'd1,  3'b010, 1'b0, 1'b0, 64'd1);
    applyStimulus("sltu",    ALL1,     64'd1,  3'b011, 1'b0, 1'b0, 64'd0);
    applyStimulus("xor",     64'hF0,   64'h3C, 3'b100, 1'b0, 1'b0, 64'hCC);
    applyStimulus("or",      64'hF0,   64'h3C, 3'b110, 1'b0, 1'b0, 64'hFC);
    applyStimulus("and",     64'hF0,   64'h3C, 3'b111, 1'b0, 1'b0, 64'h30);

    applyStimulus("mul",     64'd6,    64'd7,  3'b000, 1'b0, 1'b1, 64'd42);
    applyStimulus("mulh",    64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 3'b001, 1'b0, 1'b1, ALL1);
    applyStimulus("mulhsu",  ALL1,     64'd2,  3'b010, 1'b0, 1'b1, ALL1);
    applyStimulus("mulhu",   ALL1,     ALL1,   3'b011, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
    applyStimulus("div0",    64'd42,   64'd0,  3'b100, 1'b0, 1'b1, ALL1);
    applyStimulus("rem0",    64'd42,   64'd0,  3'b110, 1'b0, 1'b1, 64'd42);
    applyStimulus("div_ovf", MINV,     ALL1,   3'b100, 1'b0, 1'b1, MINV);
    applyStimulus("rem_ovf", MINV,     ALL1,   3'b110, 1'b0, 1'b1, 64'd0);
    applyStimulus("div_neg", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 3'b100, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD);
    applyStimulus("rem_neg", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 3'b110, 1'b0, 1'b1, ALL1);
    applyStimulus("divu",    64'd100,  64'd7,  3'b101, 1'b0, 1'b1, 64'd14);
    applyStimulus("remu",    64'd100,  64'd7,  3'b111, 1'b0, 1'b1, 64'd2);

    // kill during IDLE must block the accept
    @(negedge clk);
    @(negedge clk);
    a       = 64'd1;
    b       = 64'd1;
    func    = 3'b000;
    sub_sra = 1'b0;
    m_ext   = 1'b0;
    valid_i = 1'b1;
    kill_i  = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    kill_i  = 1'b0;
    checkBit("idle_kill_ready", ready_o, 1'b1);
    repeat (3) @(negedge clk);

    // kill on cycle 10 of a divu: back to IDLE, no result, previous s held
    startOp(64'd1000, 64'd3, 3'b101, 1'b0, 1'b1, 1'b0);
    repeat (9) @(negedge clk);
    kill_i = 1'b1;
    @(negedge clk);
    kill_i = 1'b0;
    checkBit("kill_ready", ready_o, 1'b1);
    checkBit("kill_valid", out_valid, 1'b0);
    checkOutput("kill_hold_s", s, 64'd2);
    repeat (70) @(negedge clk);
    applyStimulus("post_kill", 64'd1000, 64'd3, 3'b101, 1'b0, 1'b1, 64'd333);

    // reset on cycle 30 of a mul: immediate reset values, nothing after release
    startOp(64'd123, 64'd456, 3'b000, 1'b0, 1'b1, 1'b0);
    repeat (29) @(negedge clk);
    rst_n  = 1'b0;
    holdS  = '0;
    holdEq = 1'b0;
    holdLs = 1'b0;
    holdLu = 1'b0;
    #1;
    checkOutput("midrst_s", s, 64'd0);
    checkBit("midrst_valid", out_valid, 1'b0);
    checkBit("midrst_eq", eq, 1'b0);
    checkBit("midrst_ls", ls, 1'b0);
    checkBit("midrst_lu", lu, 1'b0);
    checkBit("midrst_ready", ready_o, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("post_reset", 64'd2, 64'd3, 3'b000, 1'b0, 1'b0, 64'd5);
    repeat (80) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
